// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: syncs the controller's byte-ready flag and acks it.
// Decodes E0/F0 prefixes into key events and tracks the flap key.
// Ports: clk, rst (async, active high), received, received_data[7:0] in;
//   read_ack, key_code[7:0], key_extended, key_released, key_valid,
//   flap, flap_held out.
module ps2_scancode_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FLAP_CODE   = 8'h29,
  parameter int         ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] received_data,
  output logic       read_ack,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_valid,
  output logic       flap,
  output logic       flap_held
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_q;
  logic                   capture;
  logic                   pend_ext;
  logic                   pend_brk;
  logic [CW-1:0]          cnt;
  logic                   is_e0;
  logic                   is_f0;
  logic                   is_drop;
  logic                   is_flap;

  assign rx_s    = sync[SYNC_STAGES-1];
  // Level-high alone never captures: only a fresh rising edge does.
  assign capture = (state == IDLE) && rx_s && !rx_q;

  always_comb begin
    is_e0   = (received_data == 8'hE0);
    is_f0   = (received_data == 8'hF0);
    is_drop = 1'b0;
    case (received_data)
      8'h00, 8'hAA, 8'hEE,
      8'hFA, 8'hFC, 8'hFF: is_drop = 1'b1;
      default:             is_drop = 1'b0;
    endcase
    is_flap = (received_data == FLAP_CODE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sync         <= '0;
      rx_q         <= 1'b0;
      pend_ext     <= 1'b0;
      pend_brk     <= 1'b0;
      cnt          <= '0;
      read_ack     <= 1'b0;
      key_code     <= 8'h00;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_valid    <= 1'b0;
      flap         <= 1'b0;
      flap_held    <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], received};
      rx_q      <= rx_s;
      key_valid <= 1'b0;
      flap      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture) begin
            state    <= ACK;
            cnt      <= '0;
            read_ack <= 1'b1;
            unique case (1'b1)
              is_e0:   pend_ext <= 1'b1;
              is_f0:   pend_brk <= 1'b1;
              is_drop: begin
                pend_ext <= 1'b0;
                pend_brk <= 1'b0;
              end
              default: begin
                key_code     <= received_data;
                key_extended <= pend_ext;
                key_released <= pend_brk;
                key_valid    <= 1'b1;
                pend_ext     <= 1'b0;
                pend_brk     <= 1'b0;
                // Extended codes share numbers with plain keys; skip them.
                if (is_flap && !pend_ext) begin
                  if (pend_brk) begin
                    flap_held <= 1'b0;
                  end else begin
                    flap      <= !flap_held;
                    flap_held <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        ACK: begin
          if (!rx_s || cnt == LAST) begin
            state    <= IDLE;
            read_ack <= 1'b0;
          end else if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder.
// Each task drives one scenario and checks its own results.
module tb_ps2_scancode_decoder;

  localparam int SS = 2;
  localparam int TO = 16;

  logic       clk;
  logic       rst;
  logic       received;
  logic [7:0] received_data;
  logic       read_ack;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       key_valid;
  logic       flap;
  logic       flap_held;

  int checks;
  int failures;
  int kv_cnt;
  int fl_cnt;
  int ack_rises;
  logic ack_prev;
  int drop_lat;
  logic kv_at_ack;

  ps2_scancode_decoder #(
    .SYNC_STAGES(SS),
    .FLAP_CODE  (8'h29),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .received     (received),
    .received_data(received_data),
    .read_ack     (read_ack),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_released (key_released),
    .key_valid    (key_valid),
    .flap         (flap),
    .flap_held    (flap_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (key_valid) kv_cnt++;
    if (flap) fl_cnt++;
    if (read_ack && !ack_prev) ack_rises++;
    ack_prev = read_ack;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    kv_cnt    = 0;
    fl_cnt    = 0;
    ack_rises = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    received = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clr_counts();
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    received_data = b;
    received      = 1'b1;
    n = 0;
    while (!read_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!read_ack) begin
      failures++;
      $display("FAIL ack_rise: read_ack=%b expected 1", read_ack);
    end
    kv_at_ack = key_valid;
    received  = 1'b0;
    n = 0;
    while (read_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    drop_lat = n;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk("rst_ack", read_ack, 0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_ext", key_extended, 0);
    chk("rst_rel", key_released, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_flap", flap, 0);
    chk("rst_held", flap_held, 0);
  endtask

  task automatic test_flap_press();
    apply_reset();
    send(8'h29);
    chk("fp_kv_at_ack", kv_at_ack, 1);
    chk("fp_kv_cnt", kv_cnt, 1);
    chk("fp_code", key_code, 8'h29);
    chk("fp_ext", key_extended, 0);
    chk("fp_rel", key_released, 0);
    chk("fp_flap_cnt", fl_cnt, 1);
    chk("fp_held", flap_held, 1);
    chk("fp_drop_lat", drop_lat, SS + 1);
    chk("fp_ack_rises", ack_rises, 1);
  endtask

  task automatic test_typematic();
    apply_reset();
    send(8'h29);
    send(8'h29);
    send(8'hF0);
    chk("tm_f0_no_kv", kv_at_ack, 0);
    send(8'h29);
    chk("tm_kv_cnt", kv_cnt, 3);
    chk("tm_flap_cnt", fl_cnt, 1);
    chk("tm_rel", key_released, 1);
    chk("tm_held", flap_held, 0);
    chk("tm_code", key_code, 8'h29);
  endtask

  task automatic test_ext_break();
    apply_reset();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("eb_kv_cnt", kv_cnt, 1);
    chk("eb_code", key_code, 8'h75);
    chk("eb_ext", key_extended, 1);
    chk("eb_rel", key_released, 1);
    clr_counts();
    send(8'hF0);
    send(8'hE0);
    send(8'h6B);
    chk("be_kv_cnt", kv_cnt, 1);
    chk("be_code", key_code, 8'h6B);
    chk("be_ext", key_extended, 1);
    chk("be_rel", key_released, 1);
    send(8'h29);
    clr_counts();
    send(8'hE0);
    send(8'hF0);
    send(8'h29);
    chk("ebf_held", flap_held, 1);
    chk("ebf_rel", key_released, 1);
    send(8'hE0);
    send(8'h29);
    chk("ef_flap_cnt", fl_cnt, 0);
    chk("ef_held", flap_held, 1);
    chk("ef_ext", key_extended, 1);
    chk("ef_rel", key_released, 0);
  endtask

  task automatic test_discard();
    apply_reset();
    send(8'hE0);
    send(8'hAA);
    chk("dc_aa_no_kv", kv_at_ack, 0);
    send(8'h1C);
    chk("dc_kv_cnt", kv_cnt, 1);
    chk("dc_code", key_code, 8'h1C);
    chk("dc_ext", key_extended, 0);
    clr_counts();
    send(8'hF0);
    send(8'hFA);
    send(8'h32);
    chk("dc2_kv_cnt", kv_cnt, 1);
    chk("dc2_rel", key_released, 0);
    chk("dc2_code", key_code, 8'h32);
    send(8'hEE);
    chk("dc2_hold", key_code, 8'h32);
  endtask

  task automatic test_timeout();
    int n;
    int late;
    apply_reset();
    received_data = 8'h1C;
    received      = 1'b1;
    n = 0;
    while (!read_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to_ack_rise", read_ack, 1);
    n = 0;
    while (read_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_high_cycles", n, TO);
    late = 0;
    repeat (20) begin
      @(negedge clk);
      if (read_ack) late++;
    end
    chk("to_no_recapture", late, 0);
    chk("to_kv_cnt", kv_cnt, 1);
    chk("to_code", key_code, 8'h1C);
    received = 1'b0;
    repeat (6) @(negedge clk);
    send(8'h24);
    chk("to_again_kv", kv_cnt, 2);
    chk("to_again_code", key_code, 8'h24);
  endtask

  task automatic test_reset_mid_ack();
    int n;
    apply_reset();
    received_data = 8'h29;
    received      = 1'b1;
    n = 0;
    while (!read_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ra_ack_pre", read_ack, 1);
    chk("ra_held_pre", flap_held, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ra_ack_drop", read_ack, 0);
    chk("ra_code", key_code, 8'h00);
    chk("ra_held", flap_held, 0);
    chk("ra_kv", key_valid, 0);
    @(negedge clk);
    clr_counts();
    rst = 1'b0;
    n = 0;
    while (!read_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ra_recap", read_ack, 1);
    received = 1'b0;
    n = 0;
    while (read_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("ra_ack_rises", ack_rises, 1);
    chk("ra_kv_cnt", kv_cnt, 1);
    chk("ra_flap_cnt", fl_cnt, 1);
    chk("ra_held_post", flap_held, 1);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    kv_at_ack     = 1'b0;
    drop_lat      = 0;
    ack_prev      = 1'b0;
    clr_counts();
    rst           = 1'b1;
    received      = 1'b0;
    received_data = 8'h00;
    test_reset();
    test_flap_press();
    test_typematic();
    test_ext_break();
    test_discard();
    test_timeout();
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on received (range 2..3).
REQ-002 The block SHALL have parameter FLAP_CODE, default 8'h29 (Space make code), giving the key that drives flap/flap_held.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 1024, giving the max clk cycles read_ack is held awaiting received low.
REQ-004 The block SHALL use one clock and an asynchronous active-high reset, named as the codebase does: clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 received  input  1  byte-ready flag from ps2controller, PS2_CLK domain, held high until acknowledged.
REQ-007 received_data  input  8  byte from ps2controller, stable while received is high.
REQ-008 read_ack  output  1  acknowledge to ps2controller.
REQ-009 key_code  output  8  last decoded scan code.
REQ-010 key_extended  output  1  last event had an E0 prefix.
REQ-011 key_released  output  1  last event had an F0 prefix (break).
REQ-012 key_valid  output  1  one-cycle pulse when key_code/key_extended/key_released update.
REQ-013 flap  output  1  one-cycle pulse on a fresh, non-repeated FLAP_CODE press.
REQ-014 flap_held  output  1  level, FLAP_CODE currently pressed.

Function
REQ-015 received SHALL pass through a SYNC_STAGES flop synchronizer (rx_s); received_data SHALL be sampled only on the capture cycle defined below.
REQ-016 A capture SHALL occur on a rising edge of rx_s (rx_s=1, previous rx_s=0) in state IDLE; a high rx_s without a rising edge SHALL never cause a capture.
REQ-017 FSM states: IDLE, ACK; IDLE->ACK on capture; ACK->IDLE when rx_s=0 or timeout counter reaches ACK_TIMEOUT-1.
REQ-018 read_ack SHALL be registered: high from the cycle after capture through the cycle ACK exits, low otherwise.
REQ-019 The timeout counter SHALL clear on capture, increment each ACK cycle, and saturate; on timeout read_ack drops and the byte is still decoded exactly once.
REQ-020 Decode happens on the capture byte, outputs registered, visible the cycle after capture (same cycle read_ack first goes high).
REQ-021 Byte 8'hE0 SHALL set the pending-extended flag, no key_valid.
REQ-022 Byte 8'hF0 SHALL set the pending-break flag, no key_valid; E0 then F0 and F0 then E0 both yield extended break.
REQ-023 Bytes 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF SHALL be discarded and SHALL clear both pending flags, no key_valid.
REQ-024 Any other byte SHALL load key_code=byte, key_extended=pending-extended, key_released=pending-break, pulse key_valid for one cycle, then clear both pending flags.
REQ-025 On a non-extended FLAP_CODE make: flap pulses one cycle only if flap_held was 0, then flap_held=1; typematic repeats (flap_held already 1) SHALL NOT pulse flap.
REQ-026 On a non-extended FLAP_CODE break: flap_held=0, no flap pulse; extended FLAP_CODE events SHALL affect neither flap nor flap_held.
REQ-027 key_code, key_extended, key_released SHALL hold their values between key_valid pulses.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, synchronizer flops=0, edge history=0, pending flags=0, counter=0, read_ack=0, key_code=8'h00, key_extended=0, key_released=0, key_valid=0, flap=0, flap_held=0.
REQ-029 Reset mid-ACK SHALL drop read_ack immediately; after release a still-high received SHALL be captured once, as synchronizer/history restart at 0 and produce a rising edge.

Verification
REQ-030 Byte 8'h29 (received held until read_ack) -> key_valid one pulse, key_code=8'h29, ext=0, rel=0, flap one pulse, flap_held=1, read_ack drops SYNC_STAGES+1 cycles after received falls.
REQ-031 Sequence 29,29,F0,29 -> flap pulses only on the first 29, key_valid three pulses, final key_released=1, flap_held=0.
REQ-032 Sequence E0,F0,75 -> single key_valid with key_code=8'h75, ext=1, rel=1; E0,29 -> flap/flap_held unchanged.
REQ-033 Sequence E0,AA,1C -> key_code=8'h1C, ext=0, exactly one key_valid.
REQ-034 received held high, never dropped -> read_ack high exactly ACK_TIMEOUT cycles, then low; no second capture until received falls and rises again.
REQ-035 rst pulsed while in ACK with received high -> read_ack low at once, all outputs at reset values, exactly one recapture after rst release.
